mmio_timer: RTL and testbench
=============================

MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'hF0, word address of register block (bits [1:0] ignored).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port addr  input  8  data-bus word address (same encoding as data-memory port).
REQ-005 SHALL have port writeData  input  32  store data from CPU.
REQ-006 SHALL have port memWrite  input  1  store strobe, sampled at clk edge.
REQ-007 SHALL have port memRead  input  1  load strobe.
REQ-008 SHALL have port readData  output  32  load data, combinational.
REQ-009 SHALL have port hit  output  1  high when addr[7:2]==BASE_ADDR[7:2].
REQ-010 SHALL have port irq  output  1  interrupt request, level.

Function
REQ-011 SHALL decode registers by addr[1:0]: 0 CTRL, 1 COUNT, 2 COMPARE, 3 STATUS.
REQ-012 CTRL SHALL hold bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bits[15:8] PRESCALE; other bits read 0.
REQ-013 STATUS SHALL hold bit0 MATCH (write-1-to-clear) and bit1 RUN (read-only copy of EN); other bits read 0.
REQ-014 readData SHALL equal the addressed register when memRead&hit, else 32'h0 (OR-able with data memory output); zero-latency, same cycle.
REQ-015 Writes SHALL occur at clk edge when memWrite&hit; non-hit writes SHALL change nothing.
REQ-016 memRead&memWrite in the same cycle SHALL return the pre-write value and perform the write.
REQ-017 Internal 8-bit prescaler pcnt SHALL, while EN=1, increment each cycle; when pcnt==PRESCALE it SHALL go to 0 and generate one tick.
REQ-018 PRESCALE=0 SHALL yield a tick every enabled cycle; PRESCALE=N SHALL yield one tick per N+1 cycles.
REQ-019 EN=0 SHALL hold pcnt at 0 and COUNT at its value.
REQ-020 On tick with COUNT!=COMPARE, COUNT SHALL increment, wrapping 32'hFFFFFFFF->0 with no flag.
REQ-021 On tick with COUNT==COMPARE, MATCH SHALL set; AUTO_RELOAD=1 -> COUNT<=0, EN stays 1; AUTO_RELOAD=0 -> COUNT holds, EN<=0 (one-shot).
REQ-022 Any CTRL write SHALL reset pcnt to 0; the first tick follows the write edge by PRESCALE+1 cycles.
REQ-023 A COUNT write coinciding with a tick SHALL win; neither increment nor match action applies that cycle.
REQ-024 A CTRL write coinciding with a one-shot match SHALL win for EN; MATCH still sets.
REQ-025 A STATUS write with bit0=1 coinciding with a match SHALL leave MATCH=1 (set wins).
REQ-026 irq SHALL equal MATCH & IRQ_EN, derived from registered state only.
REQ-027 Writes to COMPARE SHALL take effect for match comparison from the next cycle.

Reset
REQ-028 With rst=1 at a clk edge, CTRL, COUNT, pcnt, MATCH SHALL become 0 and COMPARE SHALL become 32'hFFFFFFFF; irq=0 the following cycle.
REQ-029 rst mid-count SHALL abandon the current prescale period; rst SHALL override any same-cycle bus write.
REQ-030 hit and readData SHALL remain combinational and valid during reset.

Verification
REQ-031 Reset: assert rst one edge, then read 0xF0..0xF3 -> 0, 0, 32'hFFFFFFFF, 0; irq=0.
REQ-032 Auto-reload: COMPARE=3, CTRL=0x7 (PRESCALE 0) -> COUNT 1,2,3 after edges 1-3 following the write, edge 4 COUNT=0, MATCH=1, irq=1, EN stays 1.
REQ-033 Prescale: CTRL=0x0401 -> COUNT increments exactly every 5 cycles; 25 cycles -> COUNT=5.
REQ-034 One-shot and wrap: COUNT=32'hFFFFFFFF, COMPARE=1, CTRL=0x1 -> ticks give COUNT 0,1, then MATCH=1, EN=0, COUNT holds 1, irq=0 (IRQ_EN=0).
REQ-035 Collisions: STATUS write 0x1 on the match edge -> MATCH=1; COUNT write 0x100 on a tick edge -> COUNT=0x100; next STATUS write 0x1 -> MATCH=0, irq=0.
REQ-036 Decode: write 0xDEADBEEF to addr 0x10 with BASE_ADDR 0xF0 -> hit=0, readData=0, all registers unchanged.

Source files
------------

// File: rtl/mmio_timer_if.sv
// Data-bus port of the memory-mapped timer: CPU-side strobes and data, timer-side read data,
// decode hit and interrupt.
interface mmio_timer_if;
    logic [7:0]  addr;
    logic [31:0] writeData;
    logic        memWrite;
    logic        memRead;
    logic [31:0] readData;
    logic        hit;
    logic        irq;

    modport master (output addr, writeData, memWrite, memRead, input readData, hit, irq);
    modport slave  (input addr, writeData, memWrite, memRead, output readData, hit, irq);
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit timer: CTRL/COUNT/COMPARE/STATUS words with an 8-bit prescaler,
// compare match with auto-reload or one-shot stop, and a level interrupt.
module mmio_timer #(
    parameter logic [7:0] BASE_ADDR = 8'hF0
) (
    input  logic          clk,
    input  logic          rst,
    mmio_timer_if.slave   bus
);
    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic        irq_en_q, irq_en_d;
    logic [7:0]  presc_q, presc_d;
    logic [7:0]  pcnt_q, pcnt_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        match_q, match_d;

    logic        wr_ctrl, wr_count, wr_compare, wr_status;
    logic        tick, match_ev;

    assign bus.hit = (bus.addr[7:2] == BASE_ADDR[7:2]);
    assign bus.irq = match_q & irq_en_q;

    assign wr_ctrl    = bus.memWrite && bus.hit && (bus.addr[1:0] == 2'd0);
    assign wr_count   = bus.memWrite && bus.hit && (bus.addr[1:0] == 2'd1);
    assign wr_compare = bus.memWrite && bus.hit && (bus.addr[1:0] == 2'd2);
    assign wr_status  = bus.memWrite && bus.hit && (bus.addr[1:0] == 2'd3);

    assign tick     = en_q && (pcnt_q == presc_q);
    assign match_ev = tick && (count_q == compare_q);

    // Read mux returns pre-write state, so a same-cycle read+write sees the old value.
    always_comb begin
        bus.readData = 32'h0;
        if (bus.memRead && bus.hit) begin
            case (bus.addr[1:0])
                2'd0: bus.readData = {16'h0, presc_q, 5'h0, irq_en_q, auto_q, en_q};
                2'd1: bus.readData = count_q;
                2'd2: bus.readData = compare_q;
                default: bus.readData = {30'h0, en_q, match_q};
            endcase
        end
    end

    always_comb begin
        en_d      = en_q;
        auto_d    = auto_q;
        irq_en_d  = irq_en_q;
        presc_d   = presc_q;
        pcnt_d    = pcnt_q;
        count_d   = count_q;
        compare_d = compare_q;
        match_d   = match_q;

        if (!en_q || tick)
            pcnt_d = 8'h0;
        else
            pcnt_d = pcnt_q + 8'd1;

        if (tick) begin
            if (match_ev) begin
                if (auto_q) count_d = 32'h0;
                else        en_d    = 1'b0;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        // Bus writes override the timer's own updates; MATCH set beats a W1C clear.
        if (wr_ctrl) begin
            en_d     = bus.writeData[0];
            auto_d   = bus.writeData[1];
            irq_en_d = bus.writeData[2];
            presc_d  = bus.writeData[15:8];
            pcnt_d   = 8'h0;
        end
        if (wr_count)   count_d   = bus.writeData;
        if (wr_compare) compare_d = bus.writeData;

        if (match_ev && !wr_count)
            match_d = 1'b1;
        else if (wr_status && bus.writeData[0])
            match_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            presc_q   <= 8'h0;
            pcnt_q    <= 8'h0;
            count_q   <= 32'h0;
            compare_q <= 32'hFFFF_FFFF;
            match_q   <= 1'b0;
        end else begin
            en_q      <= en_d;
            auto_q    <= auto_d;
            irq_en_q  <= irq_en_d;
            presc_q   <= presc_d;
            pcnt_q    <= pcnt_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            match_q   <= match_d;
        end
    end
endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: reset state, auto-reload, prescale, one-shot with wrap,
// address decode, write/timer collisions and reset overriding a bus write.
`timescale 1ns/100ps
module tb_mmio_timer;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mmio_timer_if bus();

    mmio_timer #(.BASE_ADDR(8'hF0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Zero-cycle register read; the small delay only lets the combinational mux settle.
    task automatic rdchk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus.addr    = a;
        bus.memRead = 1'b1;
        #0.1;
        d = bus.readData;
        bus.memRead = 1'b0;
        chk(tag, d, exp);
    endtask

    // Called at a falling edge; the write lands on the next rising edge.
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.addr      = a;
        bus.writeData = d;
        bus.memWrite  = 1'b1;
        @(negedge clk);
        bus.memWrite  = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        bus.addr      = 8'h0;
        bus.writeData = 32'h0;
        bus.memWrite  = 1'b0;
        bus.memRead   = 1'b0;
        step(2);
        rst = 1'b0;

        // reset state
        rdchk("rst_ctrl",    8'hF0, 32'h0);
        rdchk("rst_count",   8'hF1, 32'h0);
        rdchk("rst_compare", 8'hF2, 32'hFFFF_FFFF);
        rdchk("rst_status",  8'hF3, 32'h0);
        chk("rst_irq", {31'h0, bus.irq}, 32'h0);
        chk("hit_base", {31'h0, bus.hit}, 32'h1);

        // auto-reload with irq
        wr(8'hF2, 32'd3);
        wr(8'hF0, 32'h7);
        rdchk("ar_count0", 8'hF1, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step(1);
            rdchk("ar_count", 8'hF1, k);
        end
        step(1);
        rdchk("ar_reload",  8'hF1, 32'd0);
        rdchk("ar_status",  8'hF3, 32'h3);
        chk("ar_irq", {31'h0, bus.irq}, 32'h1);
        wr(8'hF0, 32'h0);
        wr(8'hF3, 32'h1);
        rdchk("ar_clr", 8'hF3, 32'h0);
        chk("ar_irq_clr", {31'h0, bus.irq}, 32'h0);

        // prescale 4 -> one tick per 5 cycles
        wr(8'hF1, 32'd0);
        wr(8'hF2, 32'd100);
        wr(8'hF0, 32'h0401);
        rdchk("ps_ctrl", 8'hF0, 32'h0401);
        step(4);
        rdchk("ps_c4", 8'hF1, 32'd0);
        step(1);
        rdchk("ps_c5", 8'hF1, 32'd1);
        step(20);
        rdchk("ps_c25", 8'hF1, 32'd5);
        wr(8'hF0, 32'h0);
        step(3);
        rdchk("ps_hold", 8'hF1, 32'd5);

        // one-shot with wrap
        wr(8'hF1, 32'hFFFF_FFFF);
        wr(8'hF2, 32'd1);
        wr(8'hF0, 32'h1);
        step(1);
        rdchk("os_wrap", 8'hF1, 32'd0);
        step(1);
        rdchk("os_one", 8'hF1, 32'd1);
        step(1);
        rdchk("os_status", 8'hF3, 32'h1);
        rdchk("os_ctrl",   8'hF0, 32'h0);
        step(2);
        rdchk("os_hold",   8'hF1, 32'd1);
        chk("os_irq", {31'h0, bus.irq}, 32'h0);

        // non-hit write
        bus.addr      = 8'h10;
        bus.writeData = 32'hDEAD_BEEF;
        bus.memWrite  = 1'b1;
        bus.memRead   = 1'b1;
        #0.1;
        chk("dec_hit",  {31'h0, bus.hit}, 32'h0);
        chk("dec_rdat", bus.readData, 32'h0);
        @(negedge clk);
        bus.memWrite = 1'b0;
        bus.memRead  = 1'b0;
        rdchk("dec_ctrl",    8'hF0, 32'h0);
        rdchk("dec_count",   8'hF1, 32'd1);
        rdchk("dec_compare", 8'hF2, 32'd1);
        rdchk("dec_status",  8'hF3, 32'h1);

        // CTRL write on a one-shot match edge keeps EN; MATCH still sets
        wr(8'hF3, 32'h1);
        wr(8'hF1, 32'd0);
        wr(8'hF0, 32'h1);
        step(1);
        wr(8'hF0, 32'h1);
        rdchk("cw_status", 8'hF3, 32'h3);
        wr(8'hF0, 32'h0);

        // W1C on the match edge, then COUNT write on a tick edge
        wr(8'hF3, 32'h1);
        wr(8'hF1, 32'd0);
        wr(8'hF2, 32'd2);
        wr(8'hF0, 32'h7);
        step(2);
        wr(8'hF3, 32'h1);
        rdchk("col_status", 8'hF3, 32'h3);
        rdchk("col_reload", 8'hF1, 32'd0);
        chk("col_irq", {31'h0, bus.irq}, 32'h1);
        wr(8'hF1, 32'h100);
        rdchk("col_cwr", 8'hF1, 32'h100);
        wr(8'hF3, 32'h1);
        rdchk("col_clr", 8'hF3, 32'h2);
        chk("col_irq_clr", {31'h0, bus.irq}, 32'h0);

        // reset beats a same-cycle write, and hit/readData stay live in reset
        rst = 1'b1;
        wr(8'hF2, 32'd5);
        rdchk("rw_compare", 8'hF2, 32'hFFFF_FFFF);
        rdchk("rw_count",   8'hF1, 32'h0);
        rdchk("rw_ctrl",    8'hF0, 32'h0);
        rst = 1'b0;
        step(3);
        rdchk("rw_idle", 8'hF1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
